// File: rtl/host_cmd_parser.sv
// host_cmd_parser: splits a 16-bit host word stream into header fields and
// a payload stream, with optional checksum compare (HOST_CMD_CHECKSUM_EN).
// Ports: clk, reset (sync, active-low); in_* host word input (valid/ready);
// hdr_* header fields + valid/ready; out_* payload stream + out_last;
// pkt_done / pkt_error one-cycle pulses; error_count saturating mismatches.
module host_cmd_parser #(
  parameter logic [7:0] simple_cmd = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_enable,
  output logic        in_ready,
  output logic [7:0]  hdr_dest,
  output logic [7:0]  hdr_cmd,
  output logic [23:0] hdr_len,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [15:0] out_data,
  output logic        out_enable,
  input  logic        out_ready,
  output logic        out_last,
  output logic        pkt_done,
  output logic        pkt_error,
  output logic [15:0] error_count
);

  typedef enum logic [2:0] {
    DEST, CMD, LEN_HI, LEN_LO, HDR, PAYLOAD, CK_HI, CK_LO
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dest_q, dest_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] len_q, len_d;
  logic [23:0] cnt_q, cnt_d;
  logic        hv_q, hv_d;
  logic        simple_q, simple_d;
  logic [15:0] odata_q, odata_d;
  logic        oen_q, oen_d;
  logic        olast_q, olast_d;
  logic        done_q, done_d;
  logic        accept;

  always_comb begin
    in_ready = 1'b1;
    unique case (state_q)
      HDR:     in_ready = 1'b0;
      PAYLOAD: in_ready = !oen_q || out_ready;
      default: in_ready = 1'b1;
    endcase
    if (!reset) in_ready = 1'b0;
  end

  assign accept = in_enable && in_ready;

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hv_d     = hv_q;
    simple_d = simple_q;
    odata_d  = odata_q;
    oen_d    = oen_q;
    olast_d  = olast_q;
    done_d   = 1'b0;
    if (oen_q && out_ready) begin
      oen_d   = 1'b0;
      olast_d = 1'b0;
    end
    unique case (state_q)
      DEST: if (accept) begin
        dest_d  = in_data[7:0];
        state_d = CMD;
      end
      CMD: if (accept) begin
        cmd_d   = in_data[7:0];
        state_d = LEN_HI;
      end
      LEN_HI: if (accept) begin
        // Simple commands carry one filler word instead of a length.
        if (cmd_q == simple_cmd) begin
          len_d    = '0;
          simple_d = 1'b1;
          hv_d     = 1'b1;
          state_d  = HDR;
        end else begin
          len_d[23:16] = in_data[7:0];
          simple_d     = 1'b0;
          state_d      = LEN_LO;
        end
      end
      LEN_LO: if (accept) begin
        len_d[15:0] = in_data;
        hv_d        = 1'b1;
        state_d     = HDR;
      end
      HDR: if (hdr_ready) begin
        hv_d = 1'b0;
        if (simple_q) begin
          done_d  = 1'b1;
          state_d = DEST;
        end else if (len_q != '0) begin
          cnt_d   = len_q;
          state_d = PAYLOAD;
        end else begin
          state_d = CK_HI;
        end
      end
      PAYLOAD: if (accept) begin
        odata_d = in_data;
        oen_d   = 1'b1;
        olast_d = (cnt_q == 24'd1);
        cnt_d   = cnt_q - 24'd1;
        if (cnt_q == 24'd1) state_d = CK_HI;
      end
      CK_HI: if (accept) state_d = CK_LO;
      CK_LO: if (accept) begin
        done_d  = 1'b1;
        state_d = DEST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= DEST;
      dest_q   <= '0;
      cmd_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      hv_q     <= 1'b0;
      simple_q <= 1'b0;
      odata_q  <= '0;
      oen_q    <= 1'b0;
      olast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      cmd_q    <= cmd_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hv_q     <= hv_d;
      simple_q <= simple_d;
      odata_q  <= odata_d;
      oen_q    <= oen_d;
      olast_q  <= olast_d;
      done_q   <= done_d;
    end
  end

  assign hdr_dest   = dest_q;
  assign hdr_cmd    = cmd_q;
  assign hdr_len    = len_q;
  assign hdr_valid  = hv_q;
  assign out_data   = odata_q;
  assign out_enable = oen_q;
  assign out_last   = olast_q;
  assign pkt_done   = done_q;

`ifdef HOST_CMD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        ckok_q, ckok_d;
  logic        perr_q, perr_d;
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    sum_d  = sum_q;
    ckok_d = ckok_q;
    perr_d = 1'b0;
    ecnt_d = ecnt_q;
    unique case (state_q)
      DEST:    sum_d = '0;
      PAYLOAD: if (accept) sum_d = sum_q + {16'h0000, in_data};
      CK_HI:   if (accept) ckok_d = (in_data == sum_q[31:16]);
      CK_LO: if (accept && !(ckok_q && in_data == sum_q[15:0])) begin
        perr_d = 1'b1;
        if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
      end
      default: sum_d = sum_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q  <= '0;
      ckok_q <= 1'b0;
      perr_q <= 1'b0;
      ecnt_q <= '0;
    end else begin
      sum_q  <= sum_d;
      ckok_q <= ckok_d;
      perr_q <= perr_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign pkt_error   = perr_q;
  assign error_count = ecnt_q;
`else
  assign pkt_error   = 1'b0;
  assign error_count = 16'h0000;
`endif

endmodule

// File: tb/tb_host_cmd_parser.sv
// tb_host_cmd_parser: randomized + directed scoreboard bench for
// host_cmd_parser with a packet-level reference model.
module tb_host_cmd_parser;
  localparam logic [7:0] SIMPLE = 8'h40;
`ifdef HOST_CMD_CHECKSUM_EN
  localparam bit CKEN = 1'b1;
`else
  localparam bit CKEN = 1'b0;
`endif

  logic        clk, reset;
  logic [15:0] in_data;
  logic        in_enable, in_ready;
  logic [7:0]  hdr_dest, hdr_cmd;
  logic [23:0] hdr_len;
  logic        hdr_valid, hdr_ready;
  logic [15:0] out_data;
  logic        out_enable, out_ready, out_last;
  logic        pkt_done, pkt_error;
  logic [15:0] error_count;

  host_cmd_parser #(.simple_cmd(SIMPLE)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_enable(in_enable), .in_ready(in_ready),
    .hdr_dest(hdr_dest), .hdr_cmd(hdr_cmd), .hdr_len(hdr_len),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .out_data(out_data), .out_enable(out_enable),
    .out_ready(out_ready), .out_last(out_last),
    .pkt_done(pkt_done), .pkt_error(pkt_error),
    .error_count(error_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 0;
  bit gaps = 0;
  int hdr_delay = 0;
  logic [15:0] exp_cnt = 0;

  logic [39:0] hdr_exp[$];
  logic [16:0] out_exp[$];
  logic [16:0] done_exp[$];
  logic [15:0] pay[$];
  logic [15:0] wq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_chk(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    int hwait;
    hwait = 0;
    forever begin
      @(posedge clk); #1;
      if (hdr_valid) begin
        hwait++;
        hdr_ready = (hwait > hdr_delay);
      end else begin
        hwait = 0;
        hdr_ready = 1'b0;
      end
    end
  end

  initial begin
    bit          held, hwt;
    logic [15:0] pdata;
    logic [39:0] phdr;
    held = 0; hwt = 0; pdata = 0; phdr = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
        hwt  = 0;
      end else begin
        if (held)
          fail_chk("out_hold", {out_enable, out_data}, {1'b1, pdata});
        if (hwt)
          fail_chk("hdr_hold", {hdr_valid, hdr_dest, hdr_cmd, hdr_len},
                   {1'b1, phdr});
        if (out_enable && out_ready) begin
          if (out_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected got %h expected none", out_data);
          end else
            fail_chk("out_word", {out_data, out_last}, out_exp.pop_front());
        end
        if (hdr_valid && hdr_ready) begin
          if (hdr_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL hdr_unexpected got %h expected none", hdr_len);
          end else
            fail_chk("hdr", {hdr_dest, hdr_cmd, hdr_len}, hdr_exp.pop_front());
        end
        if (pkt_done) begin
          if (done_exp.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected got 1 expected 0");
          end else
            fail_chk("done", {pkt_error, error_count}, done_exp.pop_front());
        end
        if (pkt_error && !pkt_done) begin
          checks++; errors++;
          $display("FAIL error_alone got 1 expected 0");
        end
        held  = out_enable && !out_ready;
        pdata = out_data;
        hwt   = hdr_valid && !hdr_ready;
        phdr  = {hdr_dest, hdr_cmd, hdr_len};
      end
    end
  end

  task automatic build(input logic [15:0] d, input logic [15:0] c,
                       input logic [1:0] corrupt);
    logic [31:0] s;
    int n;
    bit err;
    n = pay.size();
    s = 0;
    wq.push_back(d);
    wq.push_back(c);
    if (c[7:0] == SIMPLE) begin
      wq.push_back(16'h0000);
      hdr_exp.push_back({d[7:0], c[7:0], 24'd0});
      done_exp.push_back({1'b0, exp_cnt});
    end else begin
      wq.push_back({8'($urandom), 8'(n >> 16)});
      wq.push_back(16'(n));
      hdr_exp.push_back({d[7:0], c[7:0], 24'(n)});
      foreach (pay[i]) begin
        wq.push_back(pay[i]);
        out_exp.push_back({pay[i], i == n - 1});
        s += {16'h0000, pay[i]};
      end
      wq.push_back(s[31:16] ^ {15'h0, corrupt[1]});
      wq.push_back(s[15:0] ^ {15'h0, corrupt[0]});
      err = (corrupt != 0) && CKEN;
      if (err && exp_cnt != 16'hFFFF) exp_cnt++;
      done_exp.push_back({err, exp_cnt});
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    int t;
    t = 0;
    if (gaps && $urandom_range(3) == 0) begin
      in_enable = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    in_data = w;
    in_enable = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL send_timeout got stall expected in_ready");
        break;
      end
    end
    @(posedge clk); #1;
    in_enable = 1'b0;
  endtask

  task automatic send_n(input int n);
    repeat (n) if (wq.size() > 0) send_word(wq.pop_front());
  endtask

  task automatic send_all();
    while (wq.size() > 0) send_word(wq.pop_front());
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((out_exp.size() + hdr_exp.size() + done_exp.size()) > 0
           && t < 5000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    fail_chk("drain_left", out_exp.size() + hdr_exp.size() + done_exp.size(), 0);
  endtask

  task automatic check_reset_state();
    fail_chk("reset_ctrl", {in_ready, hdr_valid, out_enable, out_last,
                            pkt_done, pkt_error}, 0);
    fail_chk("reset_hdr", {hdr_dest, hdr_cmd, hdr_len}, 0);
    fail_chk("reset_data", {out_data, error_count}, 0);
  endtask

  task automatic load_basic();
    pay.delete();
    pay.push_back(16'h0061);
    pay.push_back(16'h0099);
  endtask

  task automatic load_ramp();
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back({8'(i / 256), 8'(i % 256)});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [15:0] c;
    logic [1:0]  cor;
    reset = 1'b0; in_data = 0; in_enable = 0; hdr_ready = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b1;

    load_basic();
    build(16'h0001, 16'h0020, 2'b00);
    send_all();
    drain();

    build(16'h0001, 16'h0020, 2'b01);
    send_all();
    drain();
    fail_chk("err_count_after_bad", error_count, CKEN ? 16'd1 : 16'd0);

    pay.delete();
    build(16'h00FF, 16'h0010, 2'b00);
    send_all();
    drain();

    pay.delete();
    build(16'h0000, 16'h0040, 2'b00);
    load_basic();
    build(16'h0001, 16'h0020, 2'b00);
    send_all();
    drain();

    rand_ready = 1; hdr_delay = 5;
    load_ramp();
    build(16'h0ABC, 16'h0011, 2'b00);
    send_all();
    drain();

    rand_ready = 0; hdr_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    load_ramp();
    build(16'h0102, 16'h0033, 2'b00);
    send_n(5);
    t0 = cyc;
    send_all();
    fail_chk("full_rate_cycles", cyc - t0, 257);
    drain();

    rand_ready = 1; hdr_delay = 2;
    load_ramp();
    build(16'h0007, 16'h0022, 2'b00);
    send_n(14);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_state();
    out_exp.delete(); hdr_exp.delete(); done_exp.delete(); wq.delete();
    exp_cnt = 0;
    reset = 1'b1;
    load_basic();
    build(16'h0001, 16'h0020, 2'b00);
    send_all();
    drain();

    gaps = 1;
    repeat (40) begin
      pay.delete();
      repeat ($urandom_range(0, 20)) pay.push_back(16'($urandom));
      hdr_delay = $urandom_range(0, 4);
      c = ($urandom_range(5) == 0) ? {8'($urandom), SIMPLE} : 16'($urandom);
      cor = ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      build(16'($urandom), c, cor);
      send_all();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/host_cmd_parser.md
HOST_CMD_PARSER -- requirements
Module: host_cmd_parser

Interface
REQ-001 SHALL have parameter simple_cmd, default 8'h40: command code sent as a 3-word packet (dest, cmd, one zero word) with no length, payload or checksum.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low.
- in_data  in  16  host word.
- in_enable  in  1  in_data valid.
- in_ready  out  1  parser accepts; word transfers when in_enable && in_ready.
- hdr_dest  out  8  packet destination.
- hdr_cmd  out  8  command code.
- hdr_len  out  24  payload word count.
- hdr_valid  out  1  header fields valid.
- hdr_ready  in  1  header consumed when hdr_valid && hdr_ready.
- out_data  out  16  payload word.
- out_enable  out  1  out_data valid.
- out_ready  in  1  downstream accepts; word transfers when out_enable && out_ready.
- out_last  out  1  qualifies the final payload word.
- pkt_done  out  1  one-cycle pulse at packet end.
- pkt_error  out  1  one-cycle pulse, checksum mismatch.
- error_count  out  16  saturating mismatch count.

Function
REQ-003 Packet format SHALL be: dest, cmd, len_hi, len_lo, hdr_len payload words, ck_hi, ck_lo. Only bits [7:0] of dest, cmd and len_hi SHALL be used; upper bits ignored.
REQ-004 hdr_len SHALL be {len_hi[7:0], len_lo[15:0]}.
REQ-005 States SHALL be: DEST, CMD, LEN_HI, LEN_LO, HDR, PAYLOAD, CK_HI, CK_LO.
- Each word-consuming state advances on one accepted word.
REQ-006 in_ready SHALL be 1 in DEST, CMD, LEN_HI, LEN_LO, CK_HI and CK_LO, and 0 in HDR.
REQ-007 In LEN_HI with captured cmd == simple_cmd:
- the word SHALL be consumed and hdr_len set to 0;
- after the header handshake the FSM SHALL return to DEST, pulse pkt_done, and skip checksum.
REQ-008 hdr_valid SHALL rise the cycle after len_lo is accepted and hold, with fields stable, until hdr_ready.
REQ-009 After the header handshake the FSM SHALL go to PAYLOAD if hdr_len != 0, else to CK_HI.
REQ-010 In PAYLOAD:
- in_ready SHALL be !out_enable || out_ready (one-entry output register);
- an accepted word SHALL appear on out_data the next cycle;
- full-rate streaming SHALL be sustained while out_ready is held 1.
REQ-011 A 24-bit down-counter loaded with hdr_len SHALL decrement per accepted payload word.
- out_last SHALL accompany the word taking it to 0, and the FSM SHALL then enter CK_HI.
REQ-012 Checksum SHALL be the 32-bit modulo-2^32 sum of payload words, cleared at each DEST.
- ck_hi SHALL be compared to bits [31:16] and ck_lo to bits [15:0].
REQ-013 pkt_done SHALL pulse the cycle after ck_lo is accepted.
- On mismatch pkt_error SHALL pulse in the same cycle.
- error_count SHALL increment, saturating at 16'hFFFF.
REQ-014 The FSM SHALL accept dest of the next packet the cycle after ck_lo, with no idle gap required.
REQ-015 out_enable SHALL not drop while an unaccepted word is held, regardless of in_enable.

Reset
REQ-016 While reset == 0 at a clk edge:
- the FSM SHALL enter DEST;
- counter and checksum SHALL clear;
- in_ready, hdr_valid, out_enable, out_last, pkt_done, pkt_error SHALL be 0;
- hdr_* and out_data SHALL be 0;
- error_count SHALL be 0.
REQ-017 Reset mid-packet SHALL discard the partial packet and any held output word.
- The first word accepted after release SHALL be treated as dest.

Configuration
REQ-018 Macro HOST_CMD_CHECKSUM_EN:
- Defined: checksum accumulated and compared per REQ-012/013.
- Undefined: ck_hi/ck_lo consumed and discarded, no accumulator logic, pkt_error tied 0, error_count tied 0; pkt_done unchanged.

Verification
REQ-019 Word stream 0x0001,0x0020,0x0000,0x0002,0x0061,0x0099,0x0000,0x00FA, out_ready=1 -> header dest 01 cmd 20 len 2; payload 0x0061, 0x0099 (last on second); pkt_done, no pkt_error.
REQ-020 Same packet with ck_lo=0x00FB -> pkt_error pulse, error_count=1; with macro undefined, pkt_error=0 and error_count=0.
REQ-021 0x00FF,0x0010,0x0000,0x0000,0x0000,0x0000 -> header len 0, no out_enable, pkt_done.
REQ-022 0x0000,0x0040,0x0000, then packet of REQ-019 back-to-back -> simple header len 0, then the second packet parsed correctly.
REQ-023 256-word payload (i/256, i%256 pairs), out_ready random 50%, hdr_ready delayed 5 cycles -> all 256 words in order, no loss or duplication, out_last only on word 256, no pkt_error.
REQ-024 reset low for 1 cycle after 10 payload words of a 256-word packet -> outputs per REQ-016; REQ-019 packet sent next is parsed correctly.
